// File: rtl/fmul_arb.sv
// fmul_arb: two requesters share one IEEE-754 single-precision multiplier.
// The multiplier pipeline has a 2-edge latency and accepts one operation per cycle.
//
// Ports:
//   clk, rstn                 clock; asynchronous active-low reset
//   reqN_valid/x1/x2/ready    operand request, N = 0/1 (transfer on valid&&ready)
//   respN_valid/y/ovf/unf     one-cycle result pulse with flags, N = 0/1
//   busy                      any accepted operation still in flight
//
// Build option FMUL_ARB_RR_EN: round-robin on ties (default: requester 0 wins).

module fmul (
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y,
    output logic        ovf,
    output logic        unf
);
    logic               sgn;
    logic [7:0]         ea;
    logic [7:0]         eb;
    logic               zero_a;
    logic               zero_b;
    logic               inf_a;
    logic               inf_b;
    logic               nan_in;
    logic [47:0]        prod;
    logic               norm;
    logic [22:0]        mant;
    logic               guard;
    logic               sticky;
    logic [23:0]        rnd;
    logic signed [9:0]  e;

    always_comb begin
        y      = 32'h0;
        ovf    = 1'b0;
        unf    = 1'b0;
        sgn    = x1[31] ^ x2[31];
        ea     = x1[30:23];
        eb     = x2[30:23];
        // Subnormal inputs are flushed to zero.
        zero_a = (ea == 8'h00);
        zero_b = (eb == 8'h00);
        inf_a  = (ea == 8'hff) && (x1[22:0] == 23'd0);
        inf_b  = (eb == 8'hff) && (x2[22:0] == 23'd0);
        nan_in = ((ea == 8'hff) && (x1[22:0] != 23'd0))
              || ((eb == 8'hff) && (x2[22:0] != 23'd0));
        prod   = {24'd0, 1'b1, x1[22:0]} * {24'd0, 1'b1, x2[22:0]};
        norm   = prod[47];
        if (norm) begin
            mant   = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
        end else begin
            mant   = prod[45:23];
            guard  = prod[22];
            sticky = |prod[21:0];
        end
        // Round to nearest, ties to even; a carry out bumps the exponent.
        rnd = {1'b0, mant} + {23'd0, guard & (sticky | mant[0])};
        e   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127
            + $signed({9'd0, norm}) + $signed({9'd0, rnd[23]});

        if (nan_in || (inf_a && zero_b) || (inf_b && zero_a)) begin
            y = 32'h7fc00000;
        end else if (inf_a || inf_b) begin
            y = {sgn, 8'hff, 23'd0};
        end else if (zero_a || zero_b) begin
            y = {sgn, 31'd0};
        end else if (e > 10'sd254) begin
            y   = {sgn, 8'hff, 23'd0};
            ovf = 1'b1;
        end else if (e < 10'sd1) begin
            y   = {sgn, 31'd0};
            unf = 1'b1;
        end else begin
            y = {sgn, e[7:0], rnd[22:0]};
        end
    end
endmodule

module fmul_arb (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req0_valid,
    input  logic [31:0] req0_x1,
    input  logic [31:0] req0_x2,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_x1,
    input  logic [31:0] req1_x2,
    output logic        req1_ready,
    output logic        resp0_valid,
    output logic [31:0] resp0_y,
    output logic        resp0_ovf,
    output logic        resp0_unf,
    output logic        resp1_valid,
    output logic [31:0] resp1_y,
    output logic        resp1_ovf,
    output logic        resp1_unf,
    output logic        busy
);
    typedef struct packed {
        logic        vld;
        logic        id;
        logic [31:0] x1;
        logic [31:0] x2;
    } s1_t;

    typedef struct packed {
        logic        vld;
        logic        id;
        logic [31:0] y;
        logic        ovf;
        logic        unf;
    } s2_t;

    s1_t         s1_q;
    s1_t         s1_d;
    s2_t         s2_q;
    s2_t         s2_d;
    logic        g0;
    logic        g1;
    logic        tie_to1;
    logic [31:0] m_y;
    logic        m_ovf;
    logic        m_unf;

`ifdef FMUL_ARB_RR_EN
    // rr_q set: requester 1 wins the next tie.
    logic rr_q;
    logic rr_d;

    assign tie_to1 = rr_q;

    always_comb begin
        rr_d = rr_q;
        if (g0) rr_d = 1'b1;
        if (g1) rr_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rr_q <= 1'b0;
        else       rr_q <= rr_d;
    end
`else
    assign tie_to1 = 1'b0;
`endif

    // Grants are gated by rstn so ready drops the moment reset asserts.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (rstn) begin
            unique case ({req0_valid, req1_valid})
                2'b11: begin
                    g0 = ~tie_to1;
                    g1 = tie_to1;
                end
                2'b10:   g0 = 1'b1;
                2'b01:   g1 = 1'b1;
                default: ;
            endcase
        end
    end

    assign req0_ready = g0;
    assign req1_ready = g1;

    always_comb begin
        s1_d     = s1_q;
        s1_d.vld = g0 | g1;
        if (g0 | g1) begin
            s1_d.id = g1;
            s1_d.x1 = g1 ? req1_x1 : req0_x1;
            s1_d.x2 = g1 ? req1_x2 : req0_x2;
        end
    end

    fmul u_fmul (
        .x1  (s1_q.x1),
        .x2  (s1_q.x2),
        .y   (m_y),
        .ovf (m_ovf),
        .unf (m_unf)
    );

    always_comb begin
        s2_d     = s2_q;
        s2_d.vld = s1_q.vld;
        if (s1_q.vld) begin
            s2_d.id  = s1_q.id;
            s2_d.y   = m_y;
            s2_d.ovf = m_ovf;
            s2_d.unf = m_unf;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign resp0_valid = s2_q.vld & ~s2_q.id;
    assign resp1_valid = s2_q.vld & s2_q.id;
    assign resp0_y     = s2_q.y;
    assign resp1_y     = s2_q.y;
    assign resp0_ovf   = s2_q.ovf;
    assign resp1_ovf   = s2_q.ovf;
    assign resp0_unf   = s2_q.unf;
    assign resp1_unf   = s2_q.unf;
    assign busy        = s1_q.vld | s2_q.vld;
endmodule

// File: tb/tb_fmul_arb.sv
// tb_fmul_arb: directed checks of the shared-multiplier arbiter.
// Tie expectations follow FMUL_ARB_RR_EN as built.

module tb_fmul_arb;
    logic        clk;
    logic        rstn;
    logic        req0_valid;
    logic [31:0] req0_x1;
    logic [31:0] req0_x2;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_x1;
    logic [31:0] req1_x2;
    logic        req1_ready;
    logic        resp0_valid;
    logic [31:0] resp0_y;
    logic        resp0_ovf;
    logic        resp0_unf;
    logic        resp1_valid;
    logic [31:0] resp1_y;
    logic        resp1_ovf;
    logic        resp1_unf;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef FMUL_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    fmul_arb dut (
        .clk         (clk),
        .rstn        (rstn),
        .req0_valid  (req0_valid),
        .req0_x1     (req0_x1),
        .req0_x2     (req0_x2),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_x1     (req1_x1),
        .req1_x2     (req1_x2),
        .req1_ready  (req1_ready),
        .resp0_valid (resp0_valid),
        .resp0_y     (resp0_y),
        .resp0_ovf   (resp0_ovf),
        .resp0_unf   (resp0_unf),
        .resp1_valid (resp1_valid),
        .resp1_y     (resp1_y),
        .resp1_ovf   (resp1_ovf),
        .resp1_unf   (resp1_unf),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic single_op(input string tag, input bit who,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] ey, input logic eo,
                             input logic eu);
        req0_x1 = a;
        req0_x2 = b;
        req1_x1 = a;
        req1_x2 = b;
        req0_valid = !who;
        req1_valid = who;
        #1;
        chk({tag, "_rdy"}, who ? req1_ready : req0_ready, 1);
        chk({tag, "_rdyo"}, who ? req0_ready : req1_ready, 0);
        tick();
        idle_inputs();
        tick();
        chk({tag, "_vld"}, who ? resp1_valid : resp0_valid, 1);
        chk({tag, "_vldo"}, who ? resp0_valid : resp1_valid, 0);
        chk({tag, "_y"}, who ? resp1_y : resp0_y, ey);
        chk({tag, "_ovf"}, who ? resp1_ovf : resp0_ovf, eo);
        chk({tag, "_unf"}, who ? resp1_unf : resp0_unf, eu);
        tick();
        chk({tag, "_end"}, who ? resp1_valid : resp0_valid, 0);
    endtask

    initial begin
        bit g[4];
        int cnt;

        rstn = 1'b1;
        idle_inputs();
        req0_x1 = 32'h0;
        req0_x2 = 32'h0;
        req1_x1 = 32'h0;
        req1_x2 = 32'h0;
        #2;
        rstn = 1'b0;
        tick();
        tick();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("rst_rdy0", req0_ready, 0);
        chk("rst_rdy1", req1_ready, 0);
        chk("rst_rv0", resp0_valid, 0);
        chk("rst_rv1", resp1_valid, 0);
        chk("rst_y0", resp0_y, 32'h0);
        chk("rst_y1", resp1_y, 32'h0);
        chk("rst_flags", {resp0_ovf, resp0_unf, resp1_ovf, resp1_unf}, 0);
        chk("rst_busy", busy, 0);
        idle_inputs();
        rstn = 1'b1;

        // 1.5 * 2.0 from requester 0; busy must last exactly 2 cycles.
        req0_valid = 1'b1;
        req0_x1 = 32'h3fc00000;
        req0_x2 = 32'h40000000;
        #1;
        chk("b_rdy0", req0_ready, 1);
        chk("b_rdy1", req1_ready, 0);
        tick();
        idle_inputs();
        chk("b_busy1", busy, 1);
        chk("b_rv0_early", resp0_valid, 0);
        tick();
        chk("b_busy2", busy, 1);
        chk("b_rv0", resp0_valid, 1);
        chk("b_rv1", resp1_valid, 0);
        chk("b_y0", resp0_y, 32'h40400000);
        chk("b_fl", {resp0_ovf, resp0_unf}, 0);
        tick();
        chk("b_busy3", busy, 0);
        chk("b_rv0_end", resp0_valid, 0);

        // Four cycles of ties.
        do_reset();
        for (int i = 0; i < 4; i++) g[i] = RR ? i[0] : 1'b0;
        req0_x1 = 32'h40400000;
        req0_x2 = 32'h40400000;
        req1_x1 = 32'h3fc00000;
        req1_x2 = 32'h40000000;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                req0_valid = 1'b1;
                req1_valid = 1'b1;
                #1;
                chk("tie_rdy0", req0_ready, !g[i]);
                chk("tie_rdy1", req1_ready, g[i]);
            end else begin
                idle_inputs();
            end
            if (i >= 2) begin
                chk("tie_rv0", resp0_valid, !g[i-2]);
                chk("tie_rv1", resp1_valid, g[i-2]);
                chk("tie_y", g[i-2] ? resp1_y : resp0_y,
                    g[i-2] ? 32'h40400000 : 32'h41100000);
            end
            tick();
        end
        idle_inputs();
        tick();

        // Three back-to-back grants: busy high 4 cycles.
        cnt = 0;
        req0_x1 = 32'h3f800000;
        req0_x2 = 32'h3f800000;
        for (int c = 0; c < 9; c++) begin
            req0_valid = (c < 3);
            if (busy) cnt++;
            if (c == 4) chk("b3_busy4", busy, 1);
            if (c == 5) chk("b3_busy5", busy, 0);
            tick();
        end
        chk("b3_cnt", cnt, 4);
        idle_inputs();

        single_op("ovf", 1'b1, 32'h7f000000, 32'h7f000000,
                  32'h7f800000, 1'b1, 1'b0);
        single_op("unf", 1'b0, 32'h00800000, 32'h00800000,
                  32'h00000000, 1'b0, 1'b1);
        single_op("neg", 1'b1, 32'hbfc00000, 32'h40000000,
                  32'hc0400000, 1'b0, 1'b0);
        single_op("zero", 1'b0, 32'h00000000, 32'h40400000,
                  32'h00000000, 1'b0, 1'b0);

        // Reset one cycle after a grant discards the operation.
        req0_valid = 1'b1;
        req0_x1 = 32'h40400000;
        req0_x2 = 32'h40400000;
        #1;
        chk("r_rdy0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_x1 = 32'h3fc00000;
        req1_x2 = 32'h40000000;
        rstn = 1'b0;
        #1;
        chk("r_busy", busy, 0);
        chk("r_rdy1_in_rst", req1_ready, 0);
        chk("r_rv0", resp0_valid, 0);
        tick();
        chk("r_rv0_b", resp0_valid, 0);
        chk("r_busy_b", busy, 0);
        rstn = 1'b1;
        #1;
        chk("r_rdy1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        chk("r_rv0_c", resp0_valid, 0);
        chk("r_rv1_early", resp1_valid, 0);
        tick();
        chk("r_rv1", resp1_valid, 1);
        chk("r_rv0_d", resp0_valid, 0);
        chk("r_y1", resp1_y, 32'h40400000);
        tick();
        chk("r_rv1_end", resp1_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
